// File: rtl/pixel_tag_pkg.sv
// Shared beat type and tag helper for the pixel position tagger.
// beat_t widths come from the package localparams below.
package pixel_tag_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 10;

    typedef struct packed {
        logic [PIX_W-1:0]   data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
        logic               eof;
    } beat_t;

    // Builds one tagged beat from the current counter position and the
    // limits that are in force for the frame being streamed.
    function automatic beat_t tag_beat(
        input logic [PIX_W-1:0]   data,
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input logic [COORD_W-1:0] max_x,
        input logic [COORD_W-1:0] max_y
    );
        beat_t b;
        b.data = data;
        b.x    = x;
        b.y    = y;
        b.sof  = (x == '0) && (y == '0);
        b.eol  = (x == max_x);
        b.eof  = (x == max_x) && (y == max_y);
        return b;
    endfunction

endpackage

// File: rtl/skid_buffer_2e.sv
// Two-entry ready/valid skid buffer for beat_t: a main register facing
// downstream and a skid register that absorbs the beat arriving during a stall.
module skid_buffer_2e
    import pixel_tag_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  up_valid,
    input  beat_t up_beat,
    output logic  up_ready,
    output logic  dn_valid,
    output beat_t dn_beat,
    input  logic  dn_ready
);

    logic  main_full_r;
    logic  skid_full_r;
    beat_t main_r;
    beat_t skid_r;
    logic  up_fire;
    logic  dn_fire;

    // Ready is forced low while reset is held so nothing is accepted then.
    assign up_ready = ~skid_full_r & ~rst;
    assign up_fire  = up_valid & up_ready;
    assign dn_fire  = main_full_r & dn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_full_r <= 1'b0;
            skid_full_r <= 1'b0;
            main_r      <= '0;
            skid_r      <= '0;
        end else if (dn_fire) begin
            if (skid_full_r) begin
                main_r      <= skid_r;
                skid_full_r <= 1'b0;
            end else if (up_fire) begin
                main_r <= up_beat;
            end else begin
                main_full_r <= 1'b0;
            end
        end else if (up_fire) begin
            if (main_full_r) begin
                skid_r      <= up_beat;
                skid_full_r <= 1'b1;
            end else begin
                main_r      <= up_beat;
                main_full_r <= 1'b1;
            end
        end
    end

    assign dn_valid = main_full_r;
    assign dn_beat  = main_r;

endmodule

// File: rtl/pixel_position_tagger.sv
// Tags a raster pixel stream with column/row and frame-boundary flags,
// with limits latched per frame and a two-entry skid buffer on the output.
module pixel_position_tagger
    import pixel_tag_pkg::*;
#(
    parameter int width_p       = PIX_W,
    parameter int coord_width_p = COORD_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [coord_width_p-1:0] max_x_i,
    input  logic [coord_width_p-1:0] max_y_i,
    input  logic                     valid_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [width_p-1:0]       data_o,
    output logic [coord_width_p-1:0] x_o,
    output logic [coord_width_p-1:0] y_o,
    output logic                     sof_o,
    output logic                     eol_o,
    output logic                     eof_o,
    input  logic                     ready_i,
    output logic                     frame_done_o
);

    logic [coord_width_p-1:0] x_r;
    logic [coord_width_p-1:0] y_r;
    logic [coord_width_p-1:0] shadow_x_r;
    logic [coord_width_p-1:0] shadow_y_r;
    logic [coord_width_p-1:0] eff_max_x;
    logic [coord_width_p-1:0] eff_max_y;
    logic                     frame_active_r;
    logic                     accept;
    beat_t                    in_beat;
    beat_t                    out_beat;

    // Between frames the live limits apply directly; once a frame starts the
    // shadow copy freezes so mid-frame changes only affect the next frame.
    assign eff_max_x = frame_active_r ? shadow_x_r : max_x_i;
    assign eff_max_y = frame_active_r ? shadow_y_r : max_y_i;
    assign in_beat   = tag_beat(data_i, x_r, y_r, eff_max_x, eff_max_y);
    assign accept    = valid_i & ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_r <= '0;
            y_r <= '0;
        end else if (accept) begin
            if (in_beat.eol) begin
                x_r <= '0;
                y_r <= (y_r == eff_max_y) ? '0 : y_r + 1'b1;
            end else begin
                x_r <= x_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_active_r <= 1'b0;
            shadow_x_r     <= '0;
            shadow_y_r     <= '0;
        end else begin
            if (!frame_active_r) begin
                shadow_x_r <= max_x_i;
                shadow_y_r <= max_y_i;
            end
            if (accept) begin
                frame_active_r <= ~in_beat.eof;
            end
        end
    end

    skid_buffer_2e u_skid (
        .clk      (clk_i),
        .rst      (reset_i),
        .up_valid (valid_i),
        .up_beat  (in_beat),
        .up_ready (ready_o),
        .dn_valid (valid_o),
        .dn_beat  (out_beat),
        .dn_ready (ready_i)
    );

    assign data_o       = out_beat.data;
    assign x_o          = out_beat.x;
    assign y_o          = out_beat.y;
    assign sof_o        = out_beat.sof;
    assign eol_o        = out_beat.eol;
    assign eof_o        = out_beat.eof;
    assign frame_done_o = valid_o & ready_i & out_beat.eof;

endmodule

// File: tb/tb_pixel_position_tagger.sv
// Directed table-driven bench for pixel_position_tagger: tagged streams,
// random backpressure, limit change between frames, 1x1 frames, async reset.
module tb_pixel_position_tagger;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [9:0] max_x_i = '0;
    logic [9:0] max_y_i = '0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ready_o;
    logic       valid_o;
    logic [7:0] data_o;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic       sof_o;
    logic       eol_o;
    logic       eof_o;
    logic       ready_i = 1'b1;
    logic       frame_done_o;

    pixel_position_tagger dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .max_x_i      (max_x_i),
        .max_y_i      (max_y_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .x_o          (x_o),
        .y_o          (y_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .ready_i      (ready_i),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] mx;
        logic [9:0] my;
        logic [9:0] x;
        logic [9:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } vec_t;

    vec_t tbl[32];
    int   ntbl = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    task automatic add(input logic [7:0] d, input logic [9:0] mx, input logic [9:0] my,
                       input logic [9:0] x, input logic [9:0] y,
                       input logic s, input logic l, input logic f);
        tbl[ntbl].data = d;
        tbl[ntbl].mx   = mx;
        tbl[ntbl].my   = my;
        tbl[ntbl].x    = x;
        tbl[ntbl].y    = y;
        tbl[ntbl].sof  = s;
        tbl[ntbl].eol  = l;
        tbl[ntbl].eof  = f;
        ntbl++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_valid"}, valid_o, 0);
        chk({pfx, "_ready"}, ready_o, 0);
        chk({pfx, "_data"}, data_o, 0);
        chk({pfx, "_x"}, x_o, 0);
        chk({pfx, "_y"}, y_o, 0);
        chk({pfx, "_flags"}, {sof_o, eol_o, eof_o, frame_done_o}, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1 chk_idle("reset");
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", ready_o, 1);
        chk("valid_after_reset", valid_o, 0);
    endtask

    // mode 0: ready_i always high; mode 1: random backpressure.
    task automatic run_table(input int start, input int n, input int mode);
        int   in_idx = start;
        int   out_idx = start;
        int   cycles = 0;
        int   occ = 0;
        logic acc_prev = 1'b0;
        logic stall_prev = 1'b0;
        logic [7:0] pd = '0;
        logic [9:0] px = '0;
        logic [9:0] py = '0;
        logic acc;
        logic xfer;
        while (out_idx < start + n && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            valid_i = (in_idx < start + n);
            if (valid_i) begin
                data_i  = tbl[in_idx].data;
                max_x_i = tbl[in_idx].mx;
                max_y_i = tbl[in_idx].my;
            end
            ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            #1;
            if (mode == 0) begin
                chk("latency_valid", valid_o, acc_prev);
            end else begin
                chk("ready_occupancy", ready_o, occ < 2);
                chk("valid_occupancy", valid_o, occ > 0);
                if (stall_prev) begin
                    chk("stall_valid", valid_o, 1);
                    chk("stall_hold", {data_o, x_o, y_o}, {pd, px, py});
                end
            end
            acc  = valid_i & ready_o;
            xfer = valid_o & ready_i;
            if (xfer && out_idx < start + n) begin
                chk("beat_data", data_o, tbl[out_idx].data);
                chk("beat_xy", {x_o, y_o}, {tbl[out_idx].x, tbl[out_idx].y});
                chk("beat_flags", {sof_o, eol_o, eof_o},
                    {tbl[out_idx].sof, tbl[out_idx].eol, tbl[out_idx].eof});
                chk("frame_done", frame_done_o, tbl[out_idx].eof);
                out_idx++;
            end else if (xfer) begin
                chk("extra_beat", 1, 0);
            end else begin
                chk("frame_done_idle", frame_done_o, 0);
            end
            if (acc) begin
                in_idx++;
                occ++;
            end
            if (xfer) occ--;
            acc_prev   = acc;
            stall_prev = valid_o & ~ready_i;
            pd = data_o;
            px = x_o;
            py = y_o;
        end
        if (out_idx < start + n) chk("run_timeout", out_idx, start + n);
        valid_i = 1'b0;
        ready_i = 1'b1;
    endtask

    initial begin
        // 4x2 frame, then one more beat wrapping back to sof (entries 0..8)
        add(8'h10, 3, 1, 0, 0, 1, 0, 0);
        add(8'h11, 3, 1, 1, 0, 0, 0, 0);
        add(8'h12, 3, 1, 2, 0, 0, 0, 0);
        add(8'h13, 3, 1, 3, 0, 0, 1, 0);
        add(8'h14, 3, 1, 0, 1, 0, 0, 0);
        add(8'h15, 3, 1, 1, 1, 0, 0, 0);
        add(8'h16, 3, 1, 2, 1, 0, 0, 0);
        add(8'h17, 3, 1, 3, 1, 0, 1, 1);
        add(8'h18, 3, 1, 0, 0, 1, 0, 0);
        // max_x drops 3 -> 1 at beat 2; takes effect next frame (entries 9..20)
        add(8'h40, 3, 1, 0, 0, 1, 0, 0);
        add(8'h41, 3, 1, 1, 0, 0, 0, 0);
        add(8'h42, 1, 1, 2, 0, 0, 0, 0);
        add(8'h43, 1, 1, 3, 0, 0, 1, 0);
        add(8'h44, 1, 1, 0, 1, 0, 0, 0);
        add(8'h45, 1, 1, 1, 1, 0, 0, 0);
        add(8'h46, 1, 1, 2, 1, 0, 0, 0);
        add(8'h47, 1, 1, 3, 1, 0, 1, 1);
        add(8'h48, 1, 1, 0, 0, 1, 0, 0);
        add(8'h49, 1, 1, 1, 0, 0, 1, 0);
        add(8'h4A, 1, 1, 0, 1, 0, 0, 0);
        add(8'h4B, 1, 1, 1, 1, 0, 1, 1);
        // 1x1 frames (entries 21..23)
        add(8'hA0, 0, 0, 0, 0, 1, 1, 1);
        add(8'hA1, 0, 0, 0, 0, 1, 1, 1);
        add(8'hA2, 0, 0, 0, 0, 1, 1, 1);

        do_reset();
        run_table(0, 9, 0);
        do_reset();
        run_table(0, 9, 1);
        do_reset();
        run_table(9, 12, 0);
        do_reset();
        run_table(21, 3, 0);

        // Reset asserted asynchronously with the x=2 beat held in the buffer
        do_reset();
        run_table(0, 2, 0);
        @(posedge clk);
        #1 valid_i = 1'b1;
        data_i  = 8'h5A;
        max_x_i = 3;
        max_y_i = 1;
        ready_i = 1'b0;
        @(posedge clk);
        #1 valid_i = 1'b0;
        chk("held_valid", valid_o, 1);
        chk("held_x", x_o, 2);
        #2 reset_i = 1'b1;
        #1 chk_idle("async_reset");
        repeat (2) @(posedge clk);
        #3 reset_i = 1'b0;
        ready_i = 1'b1;
        run_table(0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
